// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the memory-mapped interrupt
// controller (irq_controller) and its optional machine timer (irq_timer).
package irq_pkg;

    localparam int NUM_SRC = 4;

    // Register window offsets (byte offsets within the 64-byte window)
    localparam logic [5:0] OFF_PENDING     = 6'h00;
    localparam logic [5:0] OFF_ENABLE      = 6'h04;
    localparam logic [5:0] OFF_CLAIM       = 6'h08;
    localparam logic [5:0] OFF_EDGE        = 6'h0C;
    localparam logic [5:0] OFF_MTIME_LO    = 6'h10;
    localparam logic [5:0] OFF_MTIME_HI    = 6'h14;
    localparam logic [5:0] OFF_MTIMECMP_LO = 6'h18;
    localparam logic [5:0] OFF_MTIMECMP_HI = 6'h1C;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACTIVE  = 2'd2
    } irq_state_e;

    // Index of the lowest set bit; lowest index has highest priority.
    function automatic logic [1:0] prio_idx(input logic [NUM_SRC-1:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_timer.sv
// irq_timer: 64-bit free-running mtime and mtimecmp with word-wide writes.
// A write to either mtime half replaces it and suppresses that cycle's
// increment. irq_o is the level compare mtime >= mtimecmp.
module irq_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [1:0]  wr_idx_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        irq_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    // Next-state: increment mtime unless one of its halves is written
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (wr_en_i) begin
            case (wr_idx_i)
                2'd0:    mtime_d    = {mtime_q[63:32], wdata_i};
                2'd1:    mtime_d    = {wdata_i, mtime_q[31:0]};
                2'd2:    mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
                default: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
            endcase
        end
    end

    // Timer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = mtimecmp_q;
    assign irq_o      = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/irq_controller.sv
// irq_controller: four-source interrupt controller on the data-memory port.
// Sources are latched (edge) or followed (level), the lowest-index enabled
// pending source is presented one-hot, claimed by a CLAIM load, and the
// controller stays quiet until the core retires mret.
// Optional build macro IRQ_TIMER_EN adds mtime/mtimecmp (irq_timer) and
// replaces source 0 with the timer compare level.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing presented; waiting for PENDING & ENABLE
// PRESENT | frozen winner driven on interrupt; waiting for CLAIM load
// ACTIVE  | handler owns the claimed source; waiting for mret
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  src,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    input  logic                mem_wr,
    input  logic                mem_read,
    input  logic                is_mret,
    output logic [31:0]         rdata,
    output logic [NUM_SRC-1:0]  interrupt
);

    irq_state_e         state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [NUM_SRC-1:0] irq_q, irq_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] src_q;

    logic               hit, wr_en, rd_en, claim;
    logic [5:0]         off;
    logic [NUM_SRC-1:0] src_eff, edge_eff, rise, pending, act, claim_mask;

    assign hit   = (addr[31:6] == BASE_ADDR[31:6]);
    assign off   = {addr[5:2], 2'b00};
    assign wr_en = mem_wr & hit;
    assign rd_en = mem_read & hit;

`ifdef IRQ_TIMER_EN
    logic [63:0] mtime, mtimecmp;
    logic        timer_irq;

    irq_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en && (off[5:4] == 2'b01)),
        .wr_idx_i   (off[3:2]),
        .wdata_i    (wdata),
        .mtime_o    (mtime),
        .mtimecmp_o (mtimecmp),
        .irq_o      (timer_irq)
    );

    // Source 0 becomes the timer level; it is always treated as level.
    assign src_eff  = {src[NUM_SRC-1:1], timer_irq};
    assign edge_eff = edge_q & 4'b1110;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], src[0]};
`else
    assign src_eff  = src;
    assign edge_eff = edge_q;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:NUM_SRC]};
`endif

    // Level bits follow the source directly; edge bits come from the sticky latch.
    assign rise       = src_eff & ~src_q;
    assign pending    = (edge_eff & pend_q) | (~edge_eff & src_eff);
    assign act        = pending & enable_q;
    assign claim      = rd_en && (off == OFF_CLAIM) && (state_q == PRESENT);
    assign claim_mask = claim ? (4'b0001 << sel_q) : 4'b0000;

    // Register-file writes and sticky pending update (a new edge beats a claim)
    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        pend_d   = edge_eff & ((pend_q & ~claim_mask) | rise);
        if (wr_en && (off == OFF_ENABLE)) enable_d = wdata[NUM_SRC-1:0];
        if (wr_en && (off == OFF_EDGE))   edge_d   = wdata[NUM_SRC-1:0];
    end

    // Presentation FSM next-state; winner is frozen on entry to PRESENT
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (|act) begin
                    state_d = PRESENT;
                    sel_d   = prio_idx(act);
                end
            end
            PRESENT: begin
                if (claim)            state_d = ACTIVE;
                else if (!act[sel_q]) state_d = IDLE;
            end
            ACTIVE: begin
                if (is_mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == PRESENT) ? (4'b0001 << sel_d) : 4'b0000;
    end

    // State, configuration and source history registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            irq_q    <= '0;
            enable_q <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            irq_q    <= irq_d;
            enable_q <= enable_d;
            edge_q   <= edge_d;
            pend_q   <= pend_d;
            src_q    <= src_eff;
        end
    end

    // Combinational read mux; unmapped offsets and unused bits read 0
    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (off)
                OFF_PENDING: rdata = {28'd0, pending};
                OFF_ENABLE:  rdata = {28'd0, enable_q};
                OFF_CLAIM:   rdata = (state_q == PRESENT) ? ({30'd0, sel_q} + 32'd1) : 32'd0;
                OFF_EDGE:    rdata = {28'd0, edge_q};
`ifdef IRQ_TIMER_EN
                OFF_MTIME_LO:    rdata = mtime[31:0];
                OFF_MTIME_HI:    rdata = mtime[63:32];
                OFF_MTIMECMP_LO: rdata = mtimecmp[31:0];
                OFF_MTIMECMP_HI: rdata = mtimecmp[63:32];
`endif
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign interrupt = irq_q;

endmodule
